mcca_dyn_adder: RTL and testbench

MCCA_DYN_ADDER -- requirements
Module: mcca_dyn_adder

---
 rtl/mcca_dyn_adder.sv | 79 +++++++
 tb/tb_mcca_dyn_adder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mcca_dyn_adder.sv
// mcca_dyn_adder: registered SIZE-bit adder built on a Manchester carry chain.
// The chain is cut into four-bit blocks. Each block's carry out drives the
// carry in of the next block. The outputs are registered so that they hold
// steady between rising edges, much like a precharge/evaluate stage would.
//
// state | meaning
// ------+-------------------------------------------------------------
// r_sum | sum bits of the operands sampled at the last edge (0 in reset)
// r_cout| carry out of the last sampled operation (0 in reset)
module mcca_dyn_adder #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic            cout
);

  localparam int NBLK = SIZE / 4;

  // Stop elaboration when the width cannot be split into whole four-bit blocks.
  if ((SIZE <= 0) || ((SIZE % 4) != 0)) begin : g_bad_size
    $error("mcca_dyn_adder: SIZE must be a positive multiple of 4");
  end

  logic [SIZE-1:0] w_p;
  logic [SIZE-1:0] w_g;
  logic [SIZE-1:0] w_c;     // carry into each bit position
  logic [NBLK:0]   w_blk_c; // carry into each block; the top entry is the final carry out
  logic [SIZE-1:0] w_sum;

  logic [SIZE-1:0] r_sum;
  logic            r_cout;

  // Per-bit propagate and generate terms.
  always_comb begin
    w_p = a ^ b;
    w_g = a & b;
  end

  // Manchester chain, one four-bit block at a time. Each block's carry out
  // becomes the carry into the next block.
  always_comb begin
    w_c        = '0;
    w_blk_c    = '0;
    w_blk_c[0] = cin;
    for (int k = 0; k < NBLK; k++) begin
      w_c[4*k] = w_blk_c[k];
      for (int j = 0; j < 3; j++) begin
        w_c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_c[4*k+j]);
      end
      w_blk_c[k+1] = w_g[4*k+3] | (w_p[4*k+3] & w_c[4*k+3]);
    end
  end

  // Sum bits, formed from the propagate terms and the incoming carries.
  always_comb begin
    w_sum = w_p ^ w_c;
  end

  // Output register. A synchronous reset takes priority over a new result
  // and discards whatever result was pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_blk_c[NBLK];
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_mcca_dyn_adder.sv
module tb_mcca_dyn_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cin = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [7:0]  sum8;
  logic        cout8;
  logic [15:0] sum16;
  logic        cout16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mcca_dyn_adder #(.SIZE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin),
    .sum(sum8), .cout(cout8)
  );

  mcca_dyn_adder u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin),
    .sum(sum16), .cout(cout16)
  );

  // Reference model: at every rising edge the result is either zero (reset)
  // or the plain arithmetic sum of the sampled operands.
  logic [8:0]  exp8;
  logic [16:0] exp16;

  task automatic check8(input string name, input logic [8:0] got, input logic [8:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %0s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check16(input string name, input logic [16:0] got, input logic [16:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %0s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Compare process: checks just after each edge, then again after the
  // inputs have moved mid-cycle to confirm that the outputs are holding.
  initial begin
    forever begin
      @(posedge clk);
      exp8  = rst_n ? ({1'b0, a8}  + {1'b0, b8}  + {8'b0, cin})  : 9'h0;
      exp16 = rst_n ? ({1'b0, a16} + {1'b0, b16} + {16'b0, cin}) : 17'h0;
      #1;
      check8 ("model8_edge",  {cout8, sum8},   exp8);
      check16("model16_edge", {cout16, sum16}, exp16);
      @(negedge clk);
      #3;
      check8 ("model8_hold",  {cout8, sum8},   exp8);
      check16("model16_hold", {cout16, sum16}, exp16);
    end
  end

  // Directed step on the 8-bit instance, with a hand-computed expectation.
  task automatic step8(input string name, input logic rn, input logic [7:0] a,
                       input logic [7:0] b, input logic c, input logic [8:0] want);
    @(negedge clk);
    #1;
    rst_n = rn; a8 = a; b8 = b; cin = c;
    @(posedge clk);
    #2;
    check8(name, {cout8, sum8}, want);
  endtask

  initial begin
    // Release from reset.
    step8("rst_hold0",   1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
    step8("rst_hold1",   1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
    step8("rst_release", 1'b1, 8'h00, 8'h00, 1'b0, 9'h000);
    // Carry-in only.
    step8("cin_only",    1'b1, 8'h00, 8'h00, 1'b1, 9'h001);
    step8("cin_b1",      1'b1, 8'h00, 8'h01, 1'b1, 9'h002);
    step8("b1_nocin",    1'b1, 8'h00, 8'h01, 1'b0, 9'h001);
    // Mixed operands and full propagate.
    step8("mixed",       1'b1, 8'h01, 8'h01, 1'b1, 9'h003);
    step8("full_prop1",  1'b1, 8'hFF, 8'h00, 1'b1, 9'h100);
    step8("full_prop0",  1'b1, 8'hFF, 8'h00, 1'b0, 9'h0FF);
    step8("block_cross", 1'b1, 8'h0F, 8'h01, 1'b0, 9'h010);
    // Maximum values.
    step8("max_cin1",    1'b1, 8'hFF, 8'hFF, 1'b1, 9'h1FF);
    step8("max_cin0",    1'b1, 8'hFF, 8'hFF, 1'b0, 9'h1FE);
    // Reset in the middle of a stream.
    step8("mid_rst",     1'b0, 8'h80, 8'h80, 1'b0, 9'h000);
    step8("post_rst",    1'b1, 8'h80, 8'h80, 1'b0, 9'h100);

    // Default-width full propagate, with a literal expectation.
    @(negedge clk);
    #1;
    a16 = 16'hFFFF; b16 = 16'h0000; cin = 1'b1;
    @(posedge clk);
    #2;
    check16("w16_full_prop", {cout16, sum16}, 17'h10000);

    // Random vectors on both widths, with the occasional reset mixed in.
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      #1;
      rst_n = ($urandom_range(0, 49) != 0);
      a8    = 8'($urandom);
      b8    = 8'($urandom);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      cin   = 1'($urandom);
    end

    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
